// File: rtl/rvsteel_spi_pkg.sv
// Shared definitions for the rvsteel_spi manager-side SPI controller:
// register offsets, CTRL bit positions, FSM encoding and a strobe merge helper.
package rvsteel_spi_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_CS   = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;
    localparam logic [1:0] REG_DATA = 2'd3;

    localparam int CTRL_CPOL = 0;
    localparam int CTRL_CPHA = 1;
    localparam int CTRL_BUSY = 8;

    localparam logic [3:0] LAST_EDGE = 4'd15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } spi_state_t;

    function automatic logic [31:0] apply_strobe(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rvsteel_spi_shifter.sv
// Bit engine for rvsteel_spi: half-period timing, 16-edge sequencing,
// MOSI shifting and MISO sampling for all four CPOL/CPHA modes.
module rvsteel_spi_shifter
    import rvsteel_spi_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_cpol,
    input  logic       i_cpha,
    input  logic [7:0] i_div,
    input  logic       i_miso,
    output logic       o_busy,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_done,
    output logic [7:0] o_rx_byte
);

    spi_state_t r_state;
    logic       r_cpha;
    logic [7:0] r_div;
    logic [7:0] r_hcnt;
    logic [3:0] r_edge;
    logic [2:0] r_bit;
    logic [7:0] r_sh;
    logic [7:0] r_rx;
    logic       r_sclk;
    logic       r_mosi;

    logic       w_tick;
    logic       w_lead;
    logic       w_trail;
    logic       w_sample;
    logic       w_shift;
    logic [7:0] w_rx;

    assign w_tick  = (r_state == ST_XFER) && (r_hcnt == r_div);
    assign w_lead  = w_tick && !r_edge[0];
    assign w_trail = w_tick && r_edge[0];

    // CPHA=0 never shifts on the final trailing edge: the byte is already out
    assign w_sample = r_cpha ? w_trail : w_lead;
    assign w_shift  = r_cpha ? w_lead : (w_trail && (r_edge != LAST_EDGE));

    always_comb begin
        w_rx = r_rx;
        if (w_sample) begin
            w_rx[r_bit] = i_miso;
        end
    end

    assign o_done    = w_tick && (r_edge == LAST_EDGE);
    assign o_rx_byte = w_rx;
    assign o_busy    = (r_state == ST_XFER);
    assign o_sclk    = r_sclk;
    assign o_mosi    = r_mosi;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cpha  <= 1'b0;
            r_div   <= 8'd0;
            r_hcnt  <= 8'd0;
            r_edge  <= 4'd0;
            r_bit   <= 3'd0;
            r_sh    <= 8'd0;
            r_rx    <= 8'd0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_XFER;
                        r_cpha  <= i_cpha;
                        r_div   <= i_div;
                        r_hcnt  <= 8'd0;
                        r_edge  <= 4'd0;
                        r_bit   <= 3'd7;
                        r_rx    <= 8'd0;
                        r_sclk  <= i_cpol;
                        r_mosi  <= i_data[7];
                        // CPHA=1 re-presents bit 7 on the first leading edge
                        r_sh    <= i_cpha ? i_data : {i_data[6:0], 1'b0};
                    end
                end
                ST_XFER: begin
                    if (w_tick) begin
                        r_hcnt <= 8'd0;
                        r_edge <= r_edge + 4'd1;
                        r_sclk <= ~r_sclk;
                    end else begin
                        r_hcnt <= r_hcnt + 8'd1;
                    end
                    if (w_sample) begin
                        r_rx  <= w_rx;
                        r_bit <= r_bit - 3'd1;
                    end
                    if (w_shift) begin
                        r_mosi <= r_sh[7];
                        r_sh   <= {r_sh[6:0], 1'b0};
                    end
                    if (o_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rvsteel_spi.sv
// rvsteel_spi: bus-attached SPI manager with CTRL/CS/DIV/DATA registers.
// Define RVSTEEL_SPI_IRQ_EN to add the spi_irq / spi_irq_response ports.
module rvsteel_spi
    import rvsteel_spi_pkg::*;
#(
    parameter int NUM_CHIP_SELECTS = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [31:0]                 rw_address,
    output logic [31:0]                 read_data,
    input  logic                        read_request,
    output logic                        read_response,
    input  logic [31:0]                 write_data,
    input  logic [3:0]                  write_strobe,
    input  logic                        write_request,
    output logic                        write_response,
    output logic                        spi_sclk,
    output logic                        spi_mosi,
    input  logic                        spi_miso,
    output logic [NUM_CHIP_SELECTS-1:0] spi_cs
`ifdef RVSTEEL_SPI_IRQ_EN
   ,output logic                        spi_irq,
    input  logic                        spi_irq_response
`endif
);

    logic                        r_cpol;
    logic                        r_cpha;
    logic [NUM_CHIP_SELECTS-1:0] r_cs;
    logic [7:0]                  r_div;
    logic [7:0]                  r_rx_byte;
    logic [31:0]                 r_read_data;
    logic                        r_read_response;
    logic                        r_write_response;

    logic [1:0]  w_sel;
    logic        w_start;
    logic        w_busy;
    logic        w_sclk;
    logic        w_mosi;
    logic        w_done;
    logic [7:0]  w_rx_byte;
    logic [31:0] w_cs_ext;
    logic [31:0] w_cs_wr;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_sel   = rw_address[3:2];
    assign w_start = write_request && (w_sel == REG_DATA)
                   && write_strobe[0] && !w_busy;

    always_comb begin
        w_cs_ext = '0;
        w_cs_ext[NUM_CHIP_SELECTS-1:0] = r_cs;
    end

    assign w_cs_wr  = apply_strobe(w_cs_ext, write_data, write_strobe);
    assign w_unused = ^{rw_address[31:4], rw_address[1:0], w_cs_wr};

    rvsteel_spi_shifter u_shifter (
        .clock     (clock),
        .reset     (reset),
        .i_start   (w_start),
        .i_data    (write_data[7:0]),
        .i_cpol    (r_cpol),
        .i_cpha    (r_cpha),
        .i_div     (r_div),
        .i_miso    (spi_miso),
        .o_busy    (w_busy),
        .o_sclk    (w_sclk),
        .o_mosi    (w_mosi),
        .o_done    (w_done),
        .o_rx_byte (w_rx_byte)
    );

    // Idle SCLK tracks CPOL directly so a mode change shows up at once
    assign spi_sclk       = w_busy ? w_sclk : r_cpol;
    assign spi_mosi       = w_mosi;
    assign spi_cs         = r_cs;
    assign read_data      = r_read_data;
    assign read_response  = r_read_response;
    assign write_response = r_write_response;

    always_comb begin
        w_rdata = '0;
        unique case (w_sel)
            REG_CTRL: begin
                w_rdata[CTRL_CPOL] = r_cpol;
                w_rdata[CTRL_CPHA] = r_cpha;
                w_rdata[CTRL_BUSY] = w_busy;
            end
            REG_CS:   w_rdata      = w_cs_ext;
            REG_DIV:  w_rdata[7:0] = r_div;
            REG_DATA: w_rdata[7:0] = r_rx_byte;
            default:  w_rdata      = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cpol           <= 1'b0;
            r_cpha           <= 1'b0;
            r_cs             <= '1;
            r_div            <= 8'd0;
            r_rx_byte        <= 8'd0;
            r_read_data      <= 32'd0;
            r_read_response  <= 1'b0;
            r_write_response <= 1'b0;
        end else begin
            r_read_response  <= read_request;
            r_write_response <= write_request;
            r_read_data      <= read_request ? w_rdata : 32'd0;
            if (write_request) begin
                unique case (w_sel)
                    REG_CTRL: begin
                        if (write_strobe[0]) begin
                            r_cpol <= write_data[CTRL_CPOL];
                            r_cpha <= write_data[CTRL_CPHA];
                        end
                    end
                    REG_CS: r_cs <= w_cs_wr[NUM_CHIP_SELECTS-1:0];
                    REG_DIV: begin
                        if (write_strobe[0]) begin
                            r_div <= write_data[7:0];
                        end
                    end
                    default: ;
                endcase
            end
            if (w_done) begin
                r_rx_byte <= w_rx_byte;
            end
        end
    end

`ifdef RVSTEEL_SPI_IRQ_EN
    logic r_irq;

    assign spi_irq = r_irq;

    // A completion on the response cycle wins so no event is lost
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else if (w_done) begin
            r_irq <= 1'b1;
        end else if (spi_irq_response) begin
            r_irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_rvsteel_spi.sv
// Directed scoreboard bench for rvsteel_spi (mode 0/3 transfers, busy
// writes, strobes, reset mid-transfer and, when enabled, the interrupt).
module tb_rvsteel_spi;

    localparam int NCS = 4;
    localparam logic [31:0] A_CTRL = 32'h8003_0000;
    localparam logic [31:0] A_CS   = 32'h8003_0004;
    localparam logic [31:0] A_DIV  = 32'h8003_0008;
    localparam logic [31:0] A_DATA = 32'h8003_000C;

    logic           clock = 1'b0;
    logic           reset;
    logic [31:0]    rw_address;
    logic [31:0]    read_data;
    logic           read_request;
    logic           read_response;
    logic [31:0]    write_data;
    logic [3:0]     write_strobe;
    logic           write_request;
    logic           write_response;
    logic           spi_sclk;
    logic           spi_mosi;
    logic           spi_miso;
    logic [NCS-1:0] spi_cs;
`ifdef RVSTEEL_SPI_IRQ_EN
    logic           spi_irq;
    logic           spi_irq_response;
`endif

    logic loop_en;
    logic miso_val;
    logic mon_en;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q_rd[$];
    logic        q_bits_exp[$];
    logic        q_bits_obs[$];

    assign spi_miso = loop_en ? spi_mosi : miso_val;

    always #5 clock = ~clock;

    rvsteel_spi #(.NUM_CHIP_SELECTS(NCS)) dut (
        .clock          (clock),
        .reset          (reset),
        .rw_address     (rw_address),
        .read_data      (read_data),
        .read_request   (read_request),
        .read_response  (read_response),
        .write_data     (write_data),
        .write_strobe   (write_strobe),
        .write_request  (write_request),
        .write_response (write_response),
        .spi_sclk       (spi_sclk),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .spi_cs         (spi_cs)
`ifdef RVSTEEL_SPI_IRQ_EN
       ,.spi_irq         (spi_irq),
        .spi_irq_response(spi_irq_response)
`endif
    );

    // Mode-0 leading edges are rising; MOSI is stable there
    always @(posedge spi_sclk) begin
        if (mon_en) q_bits_obs.push_back(spi_mosi);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input string tag);
        rw_address    = a;
        write_data    = d;
        write_strobe  = s;
        write_request = 1'b1;
        tick();
        write_request = 1'b0;
        chk({tag, "_wack"}, 32'(write_response), 32'd1);
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp,
                            input string tag);
        logic [31:0] e;
        q_rd.push_back(exp);
        rw_address   = a;
        read_request = 1'b1;
        tick();
        read_request = 1'b0;
        chk({tag, "_rack"}, 32'(read_response), 32'd1);
        e = q_rd.pop_front();
        chk(tag, read_data, e);
    endtask

    task automatic push_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) q_bits_exp.push_back(b[i]);
    endtask

    task automatic check_bits(input string tag);
        logic e;
        logic o;
        chk({tag, "_count"}, 32'(q_bits_obs.size()),
            32'(q_bits_exp.size()));
        while (q_bits_exp.size() > 0) begin
            e = q_bits_exp.pop_front();
            o = (q_bits_obs.size() > 0) ? q_bits_obs.pop_front() : 1'bx;
            chk(tag, 32'(o), 32'(e));
        end
        q_bits_obs.delete();
    endtask

    // Polls BUSY every cycle and tracks SCLK toggles until BUSY drops
    task automatic run_xfer(input int exp_busy, input int exp_tog,
                            input int div, input logic idle, input string tag);
        int   i;
        int   busy;
        int   tog;
        int   t1;
        int   t2;
        logic prev;
        i = 0; busy = 0; tog = 0; t1 = -1; t2 = -1;
        prev = spi_sclk;
        rw_address   = A_CTRL;
        read_request = 1'b1;
        while (i < 4000) begin
            tick();
            i++;
            if (spi_sclk !== prev) begin
                tog++;
                if (tog == 1) t1 = i;
                if (tog == 2) t2 = i;
                prev = spi_sclk;
            end
            if (read_data[8] !== 1'b1) break;
            busy++;
        end
        read_request = 1'b0;
        tick();
        chk({tag, "_busy_cycles"}, 32'(busy), 32'(exp_busy));
        chk({tag, "_sclk_toggles"}, 32'(tog), 32'(exp_tog));
        chk({tag, "_first_edge"}, 32'(t1), 32'(div + 1));
        chk({tag, "_half_period"}, 32'(t2 - t1), 32'(div + 1));
        chk({tag, "_sclk_idle"}, 32'(spi_sclk), 32'(idle));
    endtask

    initial begin
        int   n;
        int   tg;
        logic pv;

        reset         = 1'b1;
        rw_address    = 32'd0;
        read_request  = 1'b0;
        write_data    = 32'd0;
        write_strobe  = 4'd0;
        write_request = 1'b0;
        loop_en       = 1'b0;
        miso_val      = 1'b0;
        mon_en        = 1'b0;
`ifdef RVSTEEL_SPI_IRQ_EN
        spi_irq_response = 1'b0;
`endif
        tick();
        chk("rst_cs", 32'(spi_cs), 32'hF);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_rresp", 32'(read_response), 32'd0);
        chk("rst_wresp", 32'(write_response), 32'd0);
`ifdef RVSTEEL_SPI_IRQ_EN
        chk("rst_irq", 32'(spi_irq), 32'd0);
`endif
        reset = 1'b0;
        tick();
        bus_read(A_CTRL, 32'd0, "rst_ctrl");
        bus_read(A_CS, 32'hF, "rst_csreg");
        bus_read(A_DIV, 32'd0, "rst_div");
        bus_read(A_DATA, 32'd0, "rst_data");

        // Mode 0, DIV=0, loopback
        loop_en = 1'b1;
        mon_en  = 1'b1;
        push_bits(8'hA5);
        bus_write(A_DATA, 32'hA5, 4'b0001, "m0_start");
        run_xfer(16, 16, 0, 1'b0, "m0");
        mon_en = 1'b0;
        check_bits("m0_mosi");
        bus_read(A_DATA, 32'hA5, "m0_rx");

        // Mode 3, DIV=2, MISO high
        loop_en  = 1'b0;
        miso_val = 1'b1;
        bus_write(A_CTRL, 32'h3, 4'hF, "m3_ctrl");
        bus_write(A_DIV, 32'h2, 4'hF, "m3_div");
        chk("m3_idle_high", 32'(spi_sclk), 32'd1);
        bus_write(A_DATA, 32'h3C, 4'b0001, "m3_start");
        run_xfer(48, 16, 2, 1'b1, "m3");
        bus_read(A_DATA, 32'hFF, "m3_rx");
        bus_read(A_CTRL, 32'h3, "m3_ctrl_rb");
        bus_write(A_CTRL, 32'h0, 4'hF, "m3_ctrl0");
        chk("cpol_low_next", 32'(spi_sclk), 32'd0);
        bus_write(A_DIV, 32'h0, 4'hF, "m3_div0");

        // DATA write while busy is ignored
        miso_val = 1'b0;
        mon_en   = 1'b1;
        push_bits(8'h22);
        bus_write(A_DATA, 32'h22, 4'b0001, "bw_first");
        bus_write(A_DATA, 32'h11, 4'b0001, "bw_second");
        run_xfer(15, 15, 0, 1'b0, "bw");
        repeat (5) tick();
        mon_en = 1'b0;
        check_bits("bw_mosi");
        bus_read(A_DATA, 32'h00, "bw_rx");
        bus_read(A_CTRL, 32'h0, "bw_no_second");

        // Chip selects and byte strobes
        bus_write(A_CS, 32'hFE, 4'hF, "cs_fe");
        chk("cs_drive", 32'(spi_cs), 32'hE);
        bus_write(A_CS, 32'h00, 4'h0, "cs_nostrb");
        chk("cs_hold", 32'(spi_cs), 32'hE);
        bus_read(A_CS, 32'hE, "cs_rb");
        bus_write(A_DIV, 32'h77, 4'b1110, "div_nostrb");
        bus_read(A_DIV, 32'h0, "div_rb");
        bus_write(A_DATA, 32'h99, 4'b1110, "data_nostrb");
        bus_read(A_CTRL, 32'h0, "data_nostrb_idle");

        // Simultaneous read and write returns the old value
        q_rd.push_back(32'h0);
        rw_address    = A_DIV;
        write_data    = 32'h5A;
        write_strobe  = 4'hF;
        write_request = 1'b1;
        read_request  = 1'b1;
        tick();
        write_request = 1'b0;
        read_request  = 1'b0;
        chk("rw_wack", 32'(write_response), 32'd1);
        chk("rw_rack", 32'(read_response), 32'd1);
        chk("rw_old", read_data, q_rd.pop_front());
        tick();
        chk("rw_rack_pulse", 32'(read_response), 32'd0);
        chk("rw_wack_pulse", 32'(write_response), 32'd0);
        bus_read(A_DIV, 32'h5A, "rw_new");

        // CPOL change visible the cycle after the write
        bus_write(A_CTRL, 32'h1, 4'hF, "cpol_set");
        chk("cpol_high_next", 32'(spi_sclk), 32'd1);
        bus_write(A_CTRL, 32'h0, 4'hF, "cpol_clr");

        // Reset in the middle of a transfer
        bus_write(A_CS, 32'h0, 4'hF, "mr_cs");
        bus_write(A_DIV, 32'h3, 4'hF, "mr_div");
        bus_write(A_DATA, 32'h5A, 4'b0001, "mr_start");
        n  = 0;
        tg = 0;
        pv = spi_sclk;
        while (tg < 5 && n < 500) begin
            tick();
            n++;
            if (spi_sclk !== pv) begin
                tg++;
                pv = spi_sclk;
            end
        end
        chk("mr_edges", 32'(tg), 32'd5);
        reset = 1'b1;
        #2;
        chk("mr_cs_ones", 32'(spi_cs), 32'hF);
        chk("mr_sclk", 32'(spi_sclk), 32'd0);
        chk("mr_mosi", 32'(spi_mosi), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        bus_read(A_CTRL, 32'h0, "mr_ctrl");
        bus_read(A_DATA, 32'h0, "mr_data");
        bus_read(A_DIV, 32'h0, "mr_div_rb");

`ifdef RVSTEEL_SPI_IRQ_EN
        bus_write(A_DATA, 32'h81, 4'b0001, "irq_start");
        n = 0;
        while (spi_irq !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("irq_latency", 32'(n), 32'd16);
        repeat (3) tick();
        chk("irq_hold", 32'(spi_irq), 32'd1);
        spi_irq_response = 1'b1;
        tick();
        spi_irq_response = 1'b0;
        chk("irq_clear", 32'(spi_irq), 32'd0);

        bus_write(A_DATA, 32'h42, 4'b0001, "irq_b2b_a");
        repeat (16) tick();
        chk("irq_b2b_set", 32'(spi_irq), 32'd1);
        bus_write(A_DATA, 32'h24, 4'b0001, "irq_b2b_b");
        repeat (15) tick();
        spi_irq_response = 1'b1;
        tick();
        spi_irq_response = 1'b0;
        chk("irq_b2b_keep", 32'(spi_irq), 32'd1);
        tick();
        chk("irq_b2b_still", 32'(spi_irq), 32'd1);
        spi_irq_response = 1'b1;
        tick();
        spi_irq_response = 1'b0;
        chk("irq_b2b_clear", 32'(spi_irq), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
